// File: rtl/pulse_stretcher_pkg.sv
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_ON   = 2'd1,
    STATE_GAP  = 2'd2
  } state_e;

  // Shared with the button debouncer so LED timing and input sampling rate agree.
  localparam int unsigned DEFAULT_PRESCALE  = 20000;
  localparam int unsigned DEFAULT_ON_TICKS  = 25;
  localparam int unsigned DEFAULT_GAP_TICKS = 10;
  localparam int unsigned DEFAULT_PEND_W    = 3;

endpackage

// File: rtl/pulse_stretcher_tick_prescaler.sv
module tick_prescaler
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Clear,
  output logic Tick
);

  localparam int unsigned CW = (PRESCALE == 0) ? 1 : $clog2(PRESCALE + 1);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    Tick  = (cnt_q == LAST);
    cnt_d = cnt_q + CW'(1);
    if (Clear || Tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pulse_stretcher.sv
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned PRESCALE  = DEFAULT_PRESCALE,
  parameter int unsigned ON_TICKS  = DEFAULT_ON_TICKS,
  parameter int unsigned GAP_TICKS = DEFAULT_GAP_TICKS,
  parameter int unsigned PEND_W    = DEFAULT_PEND_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Pulse,
  output logic              Led,
  output logic              Busy,
  output logic [PEND_W-1:0] Pending,
  output logic              Overflow
);

  localparam int unsigned MAX_TICKS = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int unsigned TCW       = $clog2(MAX_TICKS + 1);
  localparam logic [TCW-1:0] ON_LAST  = TCW'(ON_TICKS - 1);
  localparam logic [TCW-1:0] GAP_LAST = TCW'(GAP_TICKS - 1);

  state_e            state_q, state_d;
  logic              tick;
  logic              phase_clear;
  logic [TCW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              pend_inc, pend_dec;
  logic              led_q, led_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;

  // Restarting the prescaler on every state change makes each phase an exact
  // multiple of the tick period.
  assign phase_clear = (state_d != state_q);

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .Clock(Clock),
    .Reset(Reset),
    .Clear(phase_clear),
    .Tick (tick)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= STATE_IDLE;
      tick_cnt_q <= '0;
      pend_q     <= '0;
      led_q      <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      pend_q     <= pend_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STATE_IDLE: if (Pulse) state_d = STATE_ON;
      STATE_ON:   if (tick && (tick_cnt_q == ON_LAST)) state_d = STATE_GAP;
      STATE_GAP: begin
        if (tick && (tick_cnt_q == GAP_LAST)) begin
          state_d = ((pend_q != '0) || Pulse) ? STATE_ON : STATE_IDLE;
        end
      end
      default:    state_d = STATE_IDLE;
    endcase
  end

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (phase_clear || (state_q == STATE_IDLE)) begin
      tick_cnt_d = '0;
    end else if (tick) begin
      tick_cnt_d = tick_cnt_q + TCW'(1);
    end
  end

  // A queued event leaving on GAP->ON frees a slot, so a same-cycle arrival nets to zero.
  always_comb begin
    pend_inc = Pulse && (state_q != STATE_IDLE);
    pend_dec = (state_q == STATE_GAP) && (state_d == STATE_ON);
    pend_d   = pend_q;
    ovf_d    = 1'b0;
    if (pend_inc && !pend_dec) begin
      if (pend_q == '1) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (pend_dec && !pend_inc) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  always_comb begin
    led_d  = (state_d == STATE_ON);
    busy_d = (state_d != STATE_IDLE);
  end

  assign Led      = led_q;
  assign Busy     = busy_q;
  assign Pending  = pend_q;
  assign Overflow = ovf_q;

endmodule
